// File: rtl/everloop_pkg.sv
// Shared constants for the everloop LED path: frame geometry, host register map, status bits.
// Also used by the serializer, which walks addresses 0..MAX_MEM_ADD.
package everloop_pkg;

  localparam int unsigned NUM_LEDS      = 35;
  localparam int unsigned BYTES_PER_LED = 4;
  localparam int unsigned FRAME_BYTES   = NUM_LEDS * BYTES_PER_LED;
  localparam int unsigned MAX_MEM_ADD   = FRAME_BYTES - 1;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] LAST_BYTE_ADDR = ADDR_W'(MAX_MEM_ADD);

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 8'hF0;
  localparam logic [ADDR_W-1:0] ADDR_BRIGHT = 8'hF1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 8'hF2;
  localparam logic [ADDR_W-1:0] ADDR_FCNT   = 8'hF3;

  localparam int unsigned STATUS_PENDING = 0;
  localparam int unsigned STATUS_DROPPED = 1;
  localparam int unsigned STATUS_BANK    = 2;

  localparam int unsigned CTRL_SWAP      = 0;
  localparam int unsigned CTRL_CLR_DROP  = 1;

  // True when a byte address falls inside one frame.
  function automatic logic inFrame(input logic [ADDR_W-1:0] a);
    return a <= LAST_BYTE_ADDR;
  endfunction

endpackage

// File: rtl/everloop_frame_bank.sv
// One frame of pixel bytes in flops: a synchronous write port and two combinational
// read ports (host and serializer). Out-of-frame reads return zero.
module everloop_frame_bank
  import everloop_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] hostAddr,
  output logic [DATA_W-1:0] hostData,
  input  logic [ADDR_W-1:0] serAddr,
  output logic [DATA_W-1:0] serData
);

  logic [DATA_W-1:0] mem [FRAME_BYTES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FRAME_BYTES; i++) mem[i] <= '0;
    end else if (we && inFrame(wrAddr)) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign hostData = inFrame(hostAddr) ? mem[hostAddr] : '0;
  assign serData  = inFrame(serAddr)  ? mem[serAddr]  : '0;

endmodule

// File: rtl/everloop_framebuf.sv
// Double-buffered LED frame memory: host fills the back bank, swap is deferred to the next
// serializer frame start. Optional brightness scaling under EVERLOOP_BRIGHTNESS_EN.
module everloop_framebuf
  import everloop_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic              memRd,
  input  logic [ADDR_W-1:0] memAdd,
  output logic [DATA_W-1:0] memData,
  output logic              swapDone
);

  logic              bank;
  logic              pending;
  logic              dropped;
  logic [7:0]        frameCnt;

  logic              frameStart_c;
  logic              swap_c;
  logic              pixWr_c;
  logic              ctrlWr_c;
  logic              effBank_c;
  logic [DATA_W-1:0] host0_c, host1_c, ser0_c, ser1_c;
  logic [DATA_W-1:0] rawByte_c;
  logic [DATA_W-1:0] readVal_c;
  logic [DATA_W-1:0] status_c;

  assign frameStart_c = memRd && (memAdd == '0);
  assign swap_c       = frameStart_c && pending;
  assign pixWr_c      = wr && inFrame(addr);
  assign ctrlWr_c     = wr && (addr == ADDR_CTRL);

  // Back bank is ~bank; pixel writes are dropped while a swap is pending.
  everloop_frame_bank u_bank0 (
    .clk(clk), .rst(rst), .we(pixWr_c && !pending && bank),
    .wrAddr(addr), .wrData(wdata),
    .hostAddr(addr), .hostData(host0_c),
    .serAddr(memAdd), .serData(ser0_c)
  );

  everloop_frame_bank u_bank1 (
    .clk(clk), .rst(rst), .we(pixWr_c && !pending && !bank),
    .wrAddr(addr), .wrData(wdata),
    .hostAddr(addr), .hostData(host1_c),
    .serAddr(memAdd), .serData(ser1_c)
  );

  // The first byte of a swapping frame already comes from the new front bank.
  assign effBank_c = bank ^ swap_c;
  assign rawByte_c = effBank_c ? ser1_c : ser0_c;

`ifdef EVERLOOP_BRIGHTNESS_EN
  logic [7:0]  bright;
  logic [15:0] prod_c;

  assign prod_c  = 16'(rawByte_c) * 16'({1'b0, bright} + 9'd1);
  assign memData = 8'(prod_c >> 8);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bright <= 8'hFF;
    else if (wr && (addr == ADDR_BRIGHT)) bright <= wdata;
  end
`else
  assign memData = rawByte_c;
`endif

  always_comb begin
    status_c                 = '0;
    status_c[STATUS_PENDING] = pending;
    status_c[STATUS_DROPPED] = dropped;
    status_c[STATUS_BANK]    = bank;
    readVal_c                = '0;
    if (inFrame(addr)) begin
      readVal_c = bank ? host0_c : host1_c;
    end else begin
      case (addr)
        ADDR_STATUS: readVal_c = status_c;
        ADDR_FCNT:   readVal_c = frameCnt;
`ifdef EVERLOOP_BRIGHTNESS_EN
        ADDR_BRIGHT: readVal_c = bright;
`endif
        default:     readVal_c = '0;
      endcase
    end
  end

  // A CTRL swap request in a swapping cycle re-arms pending for the following frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata    <= '0;
      swapDone <= 1'b0;
      bank     <= 1'b0;
      pending  <= 1'b0;
      dropped  <= 1'b0;
      frameCnt <= '0;
    end else begin
      swapDone <= swap_c;
      if (rd) rdata <= readVal_c;
      if (swap_c) bank <= ~bank;
      if (ctrlWr_c && wdata[CTRL_SWAP]) pending <= 1'b1;
      else if (swap_c)                  pending <= 1'b0;
      if (ctrlWr_c && wdata[CTRL_CLR_DROP]) dropped <= 1'b0;
      else if (pixWr_c && pending)          dropped <= 1'b1;
      if (frameStart_c) frameCnt <= frameCnt + 8'd1;
    end
  end

endmodule

// File: doc/everloop_framebuf.md
# everloop_framebuf

Double-buffered LED frame memory sitting directly upstream of the everloop WS2812 serializer. The host (J1 bus) fills a back bank of GRBW pixel bytes and requests a swap. The serializer reads the front bank through its `memRd`/`memAdd`/`memData` port. The swap is deferred to the next frame start, so a frame on the LED ring is never torn.

## Interface
- `NUM_LEDS`, 35, number of LEDs on the ring
- `BYTES_PER_LED`, 4, bytes per LED; frame size `FRAME_BYTES` = `NUM_LEDS*BYTES_PER_LED` = 140
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `wr`  in  1  host write strobe, one cycle per write
- `rd`  in  1  host read strobe
- `addr`  in  8  host register/pixel address
- `wdata`  in  8  host write data
- `rdata`  out  8  host read data, registered
- `memRd`  in  1  serializer read strobe
- `memAdd`  in  8  serializer byte address
- `memData`  out  8  serializer byte, combinational
- `swapDone`  out  1  one-cycle pulse when a bank swap takes effect

## Operation
- Host map:
  - 0x00..FRAME_BYTES-1: back-bank pixel bytes (R/W).
  - 0xF0 CTRL (W): bit0 requests a swap; bit1 clears `dropped`.
  - 0xF1 BRIGHT (R/W, macro only).
  - 0xF2 STATUS (R): bit0 `pending`, bit1 `dropped`, bit2 `bank`.
  - 0xF3 FRAME_CNT (R).
  - Other addresses: writes ignored, reads return 0x00.
- `bank` selects the front bank; the back bank is `~bank`.
- Writing CTRL bit0=1 sets `pending`.
- While `pending`=1, pixel writes are dropped and set sticky `dropped`. CTRL writes are still accepted.
- Frame start: a cycle with `memRd`=1 and `memAdd`=0.
  - At frame start with `pending`=1: toggle `bank`, clear `pending`, pulse `swapDone` the following cycle.
  - Every frame start increments FRAME_CNT, 8-bit, wrapping 0xFF->0x00.
- `memData` = front[`memAdd`], where the effective bank = `bank ^ (pending & memRd & memAdd==0)`. The first byte of a swapped frame therefore already comes from the new bank.
- `memAdd` >= FRAME_BYTES: `memData` = 0x00.
- `memData` is driven regardless of `memRd`; `memRd` is used only for frame-start detection.
- Host CTRL swap request in the same cycle as a frame start:
  - `pending` was 0 beforehand, so no swap occurs in this frame.
  - `pending` becomes 1, and the swap happens at the next frame start.
- `wr` and `rd` in the same cycle: both performed. `rdata` returns the pre-write value.

## Timing
- Reset values:
  - `rdata`=0, `swapDone`=0, `bank`=0, `pending`=0, `dropped`=0, FRAME_CNT=0, BRIGHT=0xFF.
  - Both banks are cleared to 0x00, so `memData`=0x00.
- Reset mid-frame takes effect immediately, with no completion of any swap.
- Host write: the value is visible at the edge ending the `wr` cycle.
- Host read: `rdata` is valid in the cycle after `rd` and holds until the next `rd`.
- Serializer: `memData` is a combinational function of `memAdd`, `bank`, `pending` and `memRd`. It is stable within the cycle `memRd` is high, so the serializer can sample it on the next edge.
- `swapDone`: high exactly one cycle, the cycle after the frame-start edge.

## Configuration
- `EVERLOOP_BRIGHTNESS_EN` defined:
  - BRIGHT register is present.
  - `memData` = (raw * (BRIGHT+1)) >> 8, using a 16-bit product and the upper 8 bits.
  - BRIGHT=0xFF is identity; BRIGHT=0x00 maps 0xFF->0x00.
- Macro undefined:
  - BRIGHT is absent: writes are ignored and reads return 0x00.
  - `memData` = raw byte.
  - No multiplier is inferred.

## Structure
- Package `everloop_pkg`:
  - NUM_LEDS, BYTES_PER_LED, FRAME_BYTES.
  - Register addresses ADDR_CTRL/ADDR_BRIGHT/ADDR_STATUS/ADDR_FCNT.
  - STATUS bit indices.
  - Shared with the serializer, whose MAX_MEM_ADD = FRAME_BYTES-1.
- Sub-module `everloop_frame_bank`:
  - One FRAME_BYTES x 8 flop array with one synchronous write port and two combinational read ports (host, serializer).
  - Instantiated twice.
  - Clear on `rst`.

## Test plan
- Reset, then serializer reads 0..139 -> `memData`=0x00 throughout; STATUS=0x00; FRAME_CNT=0.
- Host writes 0xA5 to 0x00 and 0x3C to 0x8B, then sets CTRL=0x01; serializer frame start -> `memData`=0xA5 in the memRd cycle, 0x3C at `memAdd`=0x8B; `swapDone` pulses once; STATUS bit2=1, bit0=0.
- Pixel write to 0x10 while `pending`=1 -> dropped; STATUS=0x03; CTRL=0x02 -> STATUS=0x01.
- CTRL swap request in the same cycle as a frame start -> no swap this frame; swap and `swapDone` at the next frame start.
- 256 frame starts -> FRAME_CNT wraps to 0x00; `rst` asserted mid-frame -> all state back to reset values immediately.
- `EVERLOOP_BRIGHTNESS_EN`: BRIGHT=0x7F, pixel 0xFF -> `memData`=0x7F; BRIGHT=0xFF -> 0xFF.
